inst_rom_ctrl: RTL and testbench

//   Instruction-fetch responder for pc_reg: samples pc/ce and returns the addressed word from an internal ROM.

---
 rtl/inst_rom_ctrl_pkg.sv | 34 +++
 rtl/inst_rom_ctrl_mem.sv | 17 +
 rtl/inst_rom_ctrl.sv | 135 +++++++++++++
 tb/tb_inst_rom_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_ctrl_pkg.sv
// inst_rom_ctrl_pkg: shared widths, bus constants, FSM encoding and the built-in ROM image.
`default_nettype none

package inst_rom_ctrl_pkg;

    localparam int          INST_W            = 32;
    localparam logic        RST_ENABLE        = 1'b1;
    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam int          INST_ROM_NUM_LOG2 = 10;
    localparam int          MAX_WAIT_STATES   = 15;
    localparam int          CNT_W             = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic {
        ROM_IDLE = 1'b0,
        ROM_WAIT = 1'b1
    } rom_state_e;

    // Program image; unlisted words read as NOP.
    function automatic logic [INST_W-1:0] rom_image(input logic [31:0] idx);
        logic [INST_W-1:0] word;
        case (idx)
            32'd0:   word = 32'h3401_1100;
            32'd1:   word = 32'h3402_0020;
            32'd2:   word = 32'h3403_ff00;
            32'd3:   word = 32'h3404_ffff;
            default: word = ZERO_WORD;
        endcase
        return word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_rom_ctrl_mem.sv
// inst_rom_ctrl_mem: instruction ROM array of depth 2**ROM_AW with combinational read.
`default_nettype none

module inst_rom_ctrl_mem
    import inst_rom_ctrl_pkg::*;
#(
    parameter int ROM_AW = INST_ROM_NUM_LOG2
) (
    input  logic [ROM_AW-1:0] addr_i,
    output logic [INST_W-1:0] data_o
);

    assign data_o = rom_image(32'(addr_i));

endmodule

`default_nettype wire

// File: rtl/inst_rom_ctrl.sv
// inst_rom_ctrl: instruction-fetch responder with optional wait states and stall request.
// Optional one-entry last-hit bypass enabled by macro INST_ROM_LASTHIT_EN.
`default_nettype none

module inst_rom_ctrl
    import inst_rom_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int ROM_AW      = INST_ROM_NUM_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       pc,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              stall_req,
    output logic              addr_err
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);

    rom_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              stall_raw;
    logic              serve;
    logic              hit;
    logic              in_range;
    logic [ROM_AW-1:0] idx;
    logic [INST_W-1:0] rom_word;

    assign idx      = pc[ROM_AW+1:2];
    assign in_range = (pc[1:0] == 2'b00) && ((pc >> (ROM_AW + 2)) == 32'd0);

    inst_rom_ctrl_mem #(
        .ROM_AW (ROM_AW)
    ) u_mem (
        .addr_i (idx),
        .data_o (rom_word)
    );

`ifdef INST_ROM_LASTHIT_EN
    logic [ROM_AW-1:0] tag_q;
    logic              tag_vld_q;

    assign hit = tag_vld_q && (tag_q == idx);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if (serve) begin
            tag_q     <= idx;
            tag_vld_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = ZERO_WORD;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        stall_raw = 1'b0;
        serve     = 1'b0;
        case (state_q)
            ROM_IDLE: begin
                if (ce == CHIP_ENABLE) begin
                    if (!in_range) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (NO_WAIT || hit) begin
                        serve = 1'b1;
                    end else begin
                        stall_raw = 1'b1;
                        cnt_d     = CNT_W'(WAIT_STATES - 1);
                        state_d   = ROM_WAIT;
                    end
                end
            end
            ROM_WAIT: begin
                if (ce != CHIP_ENABLE) begin
                    state_d = ROM_IDLE;
                end else if (cnt_q != '0) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    // pc is taken as presented now; it is assumed held during the stall.
                    state_d = ROM_IDLE;
                    if (!in_range) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        serve = 1'b1;
                    end
                end
            end
            default: state_d = ROM_IDLE;
        endcase
        if (serve) begin
            inst_d  = rom_word;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ROM_IDLE;
            cnt_q   <= '0;
            inst_q  <= ZERO_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign addr_err   = err_q;
    assign stall_req  = stall_raw && (rst != RST_ENABLE);

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_ctrl.sv
// tb_inst_rom_ctrl: directed bench driving a zero-wait and a three-wait instance from shared inputs.
`default_nettype none

module tb_inst_rom_ctrl;
    import inst_rom_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;

    logic [31:0] inst_f, inst_s;
    logic        valid_f, valid_s;
    logic        stall_f, stall_s;
    logic        err_f, err_s;

    int checks   = 0;
    int failures = 0;
    int n;

    localparam logic [31:0] PC_OOR = 32'h0000_0004 << INST_ROM_NUM_LOG2;

    always #5 clk = ~clk;

    inst_rom_ctrl #(.WAIT_STATES(0)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .pc         (pc),
        .inst       (inst_f),
        .inst_valid (valid_f),
        .stall_req  (stall_f),
        .addr_err   (err_f)
    );

    inst_rom_ctrl #(.WAIT_STATES(3)) u_slow (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .pc         (pc),
        .inst       (inst_s),
        .inst_valid (valid_s),
        .stall_req  (stall_s),
        .addr_err   (err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles of the slow instance until its word arrives; -1 on timeout.
    task automatic measure(output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (valid_s === 1'b1) done = 1'b1;
            else begin
                if (stall_s === 1'b1) stalls++;
                cyc();
            end
        end
        if (!done) stalls = -1;
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        pc  = 32'h0;

        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_inst_f",  inst_f,  32'h0);
            chk("rst_valid_f", valid_f, 32'h0);
            chk("rst_stall_f", stall_f, 32'h0);
            chk("rst_inst_s",  inst_s,  32'h0);
            chk("rst_valid_s", valid_s, 32'h0);
            chk("rst_stall_s", stall_s, 32'h0);
        end
        rst = 1'b0;

        pc = 32'h0; #1;
        chk("fast_stall0", stall_f, 32'h0);
        cyc();
        chk("fast_inst0",  inst_f,  32'h3401_1100);
        chk("fast_valid0", valid_f, 32'h1);
        pc = 32'h4; #1;
        chk("fast_stall1", stall_f, 32'h0);
        cyc();
        chk("fast_inst1",  inst_f,  32'h3402_0020);
        chk("fast_valid1", valid_f, 32'h1);
        pc = 32'h8; #1;
        chk("fast_stall2", stall_f, 32'h0);
        cyc();
        chk("fast_inst2",  inst_f,  32'h3403_ff00);
        chk("fast_valid2", valid_f, 32'h1);

        rst = 1'b1;
        cyc();
        rst = 1'b0; ce = 1'b1; pc = 32'h4; #1;
        chk("slow_stall_c0", stall_s, 32'h1);
        cyc();
        chk("slow_stall_c1", stall_s, 32'h1);
        chk("slow_valid_c1", valid_s, 32'h0);
        cyc();
        chk("slow_stall_c2", stall_s, 32'h1);
        cyc();
        chk("slow_stall_c3", stall_s, 32'h0);
        chk("slow_valid_c3", valid_s, 32'h0);
        cyc();
        chk("slow_inst_c4",  inst_s,  32'h3402_0020);
        chk("slow_valid_c4", valid_s, 32'h1);
        ce = 1'b0;
        cyc();
        chk("idle_valid", valid_s, 32'h0);
        chk("idle_inst",  inst_s,  32'h0);

        ce = 1'b1; pc = 32'h4;
        measure(n);
`ifdef INST_ROM_LASTHIT_EN
        chk("repeat_stalls", n, 32'd0);
`else
        chk("repeat_stalls", n, 32'd3);
`endif
        chk("repeat_inst", inst_s, 32'h3402_0020);
        ce = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; ce = 1'b1; pc = 32'h4;
        measure(n);
        chk("post_rst_stalls", n, 32'd3);
        chk("post_rst_inst", inst_s, 32'h3402_0020);
        ce = 1'b0;
        cyc();

        ce = 1'b1; pc = 32'h8; #1;
        chk("abort_stall_c0", stall_s, 32'h1);
        cyc();
        ce = 1'b0; #1;
        chk("abort_stall_drop", stall_s, 32'h0);
        cyc();
        chk("abort_valid", valid_s, 32'h0);
        chk("abort_inst",  inst_s,  32'h0);
        chk("abort_stall", stall_s, 32'h0);
        cyc();
        chk("abort_no_late", valid_s, 32'h0);
        ce = 1'b1; pc = 32'h8;
        measure(n);
        chk("after_abort_stalls", n, 32'd3);
        chk("after_abort_inst", inst_s, 32'h3403_ff00);
        ce = 1'b0;
        cyc();

        ce = 1'b1; pc = 32'h6; #1;
        chk("mis_stall_s", stall_s, 32'h0);
        chk("mis_stall_f", stall_f, 32'h0);
        cyc();
        chk("mis_inst",  inst_s,  32'h0);
        chk("mis_valid", valid_s, 32'h1);
        chk("mis_err_s", err_s,   32'h1);
        chk("mis_err_f", err_f,   32'h1);
        ce = 1'b0;
        cyc();
        chk("mis_err_pulse", err_s, 32'h0);
        chk("mis_valid_off", valid_s, 32'h0);

        ce = 1'b1; pc = PC_OOR; #1;
        chk("oor_stall_s", stall_s, 32'h0);
        cyc();
        chk("oor_inst",  inst_s,  32'h0);
        chk("oor_valid", valid_s, 32'h1);
        chk("oor_err_s", err_s,   32'h1);
        chk("oor_err_f", err_f,   32'h1);
        ce = 1'b0;
        cyc();
        chk("oor_err_pulse", err_s, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
